obi_slave_mem: RTL and testbench
================================

Name: obi_slave_mem

Overview:
- OBI responder (slave) with single-port word memory, answering the OBI master port of the SPI-slave bridge.
- Serves as the on-chip target for SPI-initiated reads/writes and as the reference target in bridge testbenches.
- Features: configurable read latency, grant stall input, byte-enabled writes, range-checked error response.
- Runs entirely in the OBI clock domain.

Parameters:
- OBI_ADDR_WIDTH, 32, byte address width.
- OBI_DATA_WIDTH, 32, data width. Only 32 is supported; elaboration fails otherwise.
- MEM_DEPTH, 256, number of 32-bit words. Must be a power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte base address of the window. Must be aligned to MEM_DEPTH*4.
- RSP_LATENCY, 1, cycles from handshake to r_valid. Range 1..4.

Ports:
- obi_aclk  in  1  clock.
- obi_aresetn  in  1  reset; synchronous, active-low.
- gnt_stall  in  1  when 1, forces obi_slave_gnt low (backpressure injection).
- obi_slave_req  in  1  request valid.
- obi_slave_gnt  out  1  request accepted.
- obi_slave_addr  in  OBI_ADDR_WIDTH  byte address.
- obi_slave_we  in  1  1 = write, 0 = read.
- obi_slave_w_data  in  OBI_DATA_WIDTH  write data.
- obi_slave_be  in  4  byte enables.
- obi_slave_r_valid  out  1  response valid; the master never stalls it.
- obi_slave_r_data  out  OBI_DATA_WIDTH  read data; 0 for writes and for errors.
- obi_slave_r_err  out  1  address outside the window.

Behaviour:
- Grant: obi_slave_gnt = obi_slave_req & ~gnt_stall, combinational.
  - Low during reset.
  - A handshake occurs in any cycle where req & gnt.
  - Up to one transaction per cycle; no outstanding-count limit, because responses cannot be backpressured.
- Decode:
  - off = addr - BASE_ADDR.
  - in_range = off < MEM_DEPTH*4, computed without wrap, i.e. addr >= BASE_ADDR.
  - Word index = off[log2(MEM_DEPTH)+1:2]; addr[1:0] is ignored.
- Write at a handshake with in_range:
  - Byte i of the word is updated with w_data[8i+7:8i] iff be[i].
  - The update takes effect at the handshake clock edge.
  - be = 0 is a legal no-op write.
- Read at a handshake with in_range: the word is sampled from the array at the handshake edge.
  - A read granted in cycle N+1 returns data written by a write granted in cycle N (no stale data).
- Out of range: writes are discarded; r_data = 0 and r_err = 1 on the response.
- Response pipeline: a shift register of RSP_LATENCY stages, each stage holding {valid, err, data}.
  - A handshake in cycle N produces r_valid = 1 in cycle N+RSP_LATENCY, for exactly one cycle.
  - Responses come back in handshake order.
  - Back-to-back handshakes give back-to-back r_valid.
  - Whenever r_valid = 0: r_data = 0 and r_err = 0.
- Writes also return a response: r_data = 0, r_err = in_range ? 0 : 1.
- gnt_stall rising while req is high: no handshake that cycle. The master holds addr/we/data; no state changes.
- Reset (obi_aresetn = 0 at a clock edge):
  - All pipeline valid bits clear.
  - Outputs become gnt = 0, r_valid = 0, r_data = 0, r_err = 0.
  - In-flight responses are dropped.
  - A request presented during reset is not granted and does not write.
  - Memory contents are not reset; they are retained across reset and undefined after power-up.
- Simultaneous events: a handshake in the same cycle as a response output is independent; the pipeline shifts and loads in the same edge.

Decomposition:
- Shared package obi_pkg:
  - obi_req_t struct {addr, we, be, w_data}.
  - obi_rsp_t struct {valid, err, data}.
  - Constant OBI_BE_WIDTH = 4.
- Sub-module obi_slave_rsp_pipe:
  - Parameterised by RSP_LATENCY; carries obi_rsp_t.
  - Uses synchronous active-low reset of the valid bits only.
- Memory array and decode live in the top.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, be 0xF, then read 0x10 with RSP_LATENCY = 1 -> write response r_valid at N+1 with r_data 0, r_err 0; read returns 0xDEADBEEF one cycle after its grant.
- Write 0x10 with data 0x11223344, be 0x5 over 0xDEADBEEF; read back -> 0xDE22BE44.
- Back-to-back reads of words 0..3 with RSP_LATENCY = 3, req held high -> gnt high 4 cycles; r_valid high 4 consecutive cycles starting 3 cycles after the first grant; data in order.
- gnt_stall = 1 for 5 cycles with req high -> gnt stays 0, no r_valid; on release the grant occurs in the same cycle and the response follows at +RSP_LATENCY.
- Address BASE_ADDR + MEM_DEPTH*4 (e.g. 0x400 for the defaults): write 0xFFFFFFFF, then read word 0x000 -> write response r_err = 1; word 0 unchanged; a read of 0x400 returns r_data 0, r_err 1.
- Reset asserted one cycle after a read grant with RSP_LATENCY = 2 -> no r_valid appears; after release, a read of the previously written word returns its retained value.

Source files
------------

// File: rtl/obi_pkg.sv
// Shared OBI types for the SPI-slave bridge codebase.
//   obi_req_t : one request beat {addr, we, be, w_data}
//   obi_rsp_t : one response beat {valid, err, data}
//   be_merge  : applies byte enables of a write onto an existing word
// The request address field is wide enough to carry any supported
// OBI_ADDR_WIDTH (zero-extended), so consumers decode from one width.
package obi_pkg;

   localparam int OBI_BE_WIDTH   = 4;
   localparam int OBI_WORD_W     = 32;
   localparam int OBI_REQ_ADDR_W = 64;

   typedef struct packed {
      logic [OBI_REQ_ADDR_W-1:0] addr;
      logic                      we;
      logic [OBI_BE_WIDTH-1:0]   be;
      logic [OBI_WORD_W-1:0]     w_data;
   } obi_req_t;

   typedef struct packed {
      logic                  valid;
      logic                  err;
      logic [OBI_WORD_W-1:0] data;
   } obi_rsp_t;

   function automatic logic [OBI_WORD_W-1:0] be_merge(
      input logic [OBI_WORD_W-1:0]   old_w,
      input logic [OBI_WORD_W-1:0]   new_w,
      input logic [OBI_BE_WIDTH-1:0] be
   );
      logic [OBI_WORD_W-1:0] res;
      res = old_w;
      for (int b = 0; b < OBI_BE_WIDTH; b++) begin
         if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/obi_slave_rsp_pipe.sv
// Fixed-latency response delay line for the OBI slave memory.
//   clk     : OBI clock
//   rst_n   : synchronous active-low reset, clears the valid bits only
//   rsp_in  : response captured at the handshake edge
//   rsp_out : response RSP_LATENCY cycles later; err/data forced to 0
//             whenever valid is 0
// The master cannot stall responses, so the line shifts every cycle.
module obi_slave_rsp_pipe
   import obi_pkg::*;
#(
   parameter int RSP_LATENCY = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  obi_rsp_t rsp_in,
   output obi_rsp_t rsp_out
);

   logic [RSP_LATENCY-1:0] vld_p;
   logic [RSP_LATENCY-1:0] err_p;
   logic [OBI_WORD_W-1:0]  data_p [RSP_LATENCY];

   // Stage 0 loads from the handshake; stage i loads from stage i-1
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= rsp_in.valid;
         for (int i = 1; i < RSP_LATENCY; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      err_p[0]  <= rsp_in.err;
      data_p[0] <= rsp_in.data;
      for (int i = 1; i < RSP_LATENCY; i++) begin
         err_p[i]  <= err_p[i-1];
         data_p[i] <= data_p[i-1];
      end
   end

   // Output boundary: payload of empty slots is never exposed
   always_comb begin
      rsp_out.valid = vld_p[RSP_LATENCY-1];
      rsp_out.err   = vld_p[RSP_LATENCY-1] & err_p[RSP_LATENCY-1];
      rsp_out.data  = vld_p[RSP_LATENCY-1] ? data_p[RSP_LATENCY-1] : '0;
   end

endmodule

// File: rtl/obi_slave_mem.sv
// OBI responder with a single-port word memory.
//   obi_aclk / obi_aresetn : clock, synchronous active-low reset
//   gnt_stall              : forces obi_slave_gnt low
//   obi_slave_req/gnt      : request handshake (gnt combinational)
//   obi_slave_addr/we/w_data/be : request payload (byte address)
//   obi_slave_r_valid/r_data/r_err : response, RSP_LATENCY cycles after
//                            the handshake; r_err flags out-of-window
// Memory contents are not reset. Writes and reads both answer; writes
// and errors return zero data.
module obi_slave_mem
   import obi_pkg::*;
#(
   parameter int                        OBI_ADDR_WIDTH = 32,
   parameter int                        OBI_DATA_WIDTH = 32,
   parameter int                        MEM_DEPTH      = 256,
   parameter logic [OBI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                        RSP_LATENCY    = 1
) (
   input  logic                      obi_aclk,
   input  logic                      obi_aresetn,
   input  logic                      gnt_stall,
   input  logic                      obi_slave_req,
   output logic                      obi_slave_gnt,
   input  logic [OBI_ADDR_WIDTH-1:0] obi_slave_addr,
   input  logic                      obi_slave_we,
   input  logic [OBI_DATA_WIDTH-1:0] obi_slave_w_data,
   input  logic [OBI_BE_WIDTH-1:0]   obi_slave_be,
   output logic                      obi_slave_r_valid,
   output logic [OBI_DATA_WIDTH-1:0] obi_slave_r_data,
   output logic                      obi_slave_r_err
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam logic [OBI_REQ_ADDR_W-1:0] MEM_BYTES = OBI_REQ_ADDR_W'(MEM_DEPTH) << 2;
   localparam logic [OBI_REQ_ADDR_W-1:0] BASE_EXT  = OBI_REQ_ADDR_W'(BASE_ADDR);

   if (OBI_DATA_WIDTH != 32) begin : g_bad_dw
      $error("obi_slave_mem: OBI_DATA_WIDTH must be 32");
   end
   if (OBI_ADDR_WIDTH < 1 || OBI_ADDR_WIDTH > OBI_REQ_ADDR_W) begin : g_bad_aw
      $error("obi_slave_mem: OBI_ADDR_WIDTH out of range");
   end
   if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("obi_slave_mem: MEM_DEPTH must be a power of two >= 2");
   end
   if ((BASE_EXT & (MEM_BYTES - 1)) != '0) begin : g_bad_base
      $error("obi_slave_mem: BASE_ADDR not aligned to the window size");
   end
   if (RSP_LATENCY < 1 || RSP_LATENCY > 4) begin : g_bad_lat
      $error("obi_slave_mem: RSP_LATENCY must be 1..4");
   end

   obi_req_t                    req_s;
   obi_rsp_t                    rsp_in;
   obi_rsp_t                    rsp_out;
   logic [OBI_WORD_W-1:0]       mem [MEM_DEPTH];
   logic                        handshake;
   logic                        in_range;
   logic [OBI_REQ_ADDR_W-1:0]   off;
   logic [IDX_W-1:0]            word_idx;

   // Gating with reset keeps requests during reset from being granted
   // or writing the array.
   assign obi_slave_gnt = obi_slave_req & ~gnt_stall & obi_aresetn;
   assign handshake     = obi_slave_gnt;

   always_comb begin
      req_s.addr   = OBI_REQ_ADDR_W'(obi_slave_addr);
      req_s.we     = obi_slave_we;
      req_s.be     = obi_slave_be;
      req_s.w_data = obi_slave_w_data;
   end

   // Decode is done at the wide width so addr - BASE never wraps into range
   assign off      = req_s.addr - BASE_EXT;
   assign in_range = (req_s.addr >= BASE_EXT) && (off < MEM_BYTES);
   assign word_idx = off[IDX_W+1:2];

   always_ff @(posedge obi_aclk) begin
      if (handshake && req_s.we && in_range) begin
         mem[word_idx] <= be_merge(mem[word_idx], req_s.w_data, req_s.be);
      end
   end

   // Handshake boundary: read data is sampled from the array before this
   // edge's write, which is fine since only one transaction fits per cycle
   always_comb begin
      rsp_in.valid = handshake;
      rsp_in.err   = ~in_range;
      rsp_in.data  = (in_range && !req_s.we) ? mem[word_idx] : '0;
   end

   obi_slave_rsp_pipe #(
      .RSP_LATENCY (RSP_LATENCY)
   ) u_rsp_pipe (
      .clk     (obi_aclk),
      .rst_n   (obi_aresetn),
      .rsp_in  (rsp_in),
      .rsp_out (rsp_out)
   );

   assign obi_slave_r_valid = rsp_out.valid;
   assign obi_slave_r_err   = rsp_out.err;
   assign obi_slave_r_data  = rsp_out.data;

endmodule

// File: tb/tb_obi_slave_mem.sv
// Directed bench for obi_slave_mem. Three instances with RSP_LATENCY 1, 2
// and 3 share one stimulus, so their memories stay identical and each
// scenario checks the instance whose latency it targets.
module tb_obi_slave_mem;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall;
   logic        req;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [3:0]  be;

   logic        gnt1, rv1, re1;
   logic [31:0] rd1;
   logic        gnt2, rv2, re2;
   logic [31:0] rd2;
   logic        gnt3, rv3, re3;
   logic [31:0] rd3;

   int vecs  = 0;
   int fails = 0;

   always #5 clk = ~clk;

   obi_slave_mem #(.RSP_LATENCY(1)) dut1 (
      .obi_aclk(clk), .obi_aresetn(rstn), .gnt_stall(stall),
      .obi_slave_req(req), .obi_slave_gnt(gnt1), .obi_slave_addr(addr),
      .obi_slave_we(we), .obi_slave_w_data(wdata), .obi_slave_be(be),
      .obi_slave_r_valid(rv1), .obi_slave_r_data(rd1), .obi_slave_r_err(re1));

   obi_slave_mem #(.RSP_LATENCY(2)) dut2 (
      .obi_aclk(clk), .obi_aresetn(rstn), .gnt_stall(stall),
      .obi_slave_req(req), .obi_slave_gnt(gnt2), .obi_slave_addr(addr),
      .obi_slave_we(we), .obi_slave_w_data(wdata), .obi_slave_be(be),
      .obi_slave_r_valid(rv2), .obi_slave_r_data(rd2), .obi_slave_r_err(re2));

   obi_slave_mem #(.RSP_LATENCY(3)) dut3 (
      .obi_aclk(clk), .obi_aresetn(rstn), .gnt_stall(stall),
      .obi_slave_req(req), .obi_slave_gnt(gnt3), .obi_slave_addr(addr),
      .obi_slave_we(we), .obi_slave_w_data(wdata), .obi_slave_be(be),
      .obi_slave_r_valid(rv3), .obi_slave_r_data(rd3), .obi_slave_r_err(re3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b);
      req = r; we = w; addr = a; wdata = d; be = b;
   endtask

   task automatic idle(input int n);
      drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rstn = 1'b0; stall = 1'b0;
      drv(1'b1, 1'b1, 32'h20, 32'hAAAA_AAAA, 4'hF);
      tick(); tick();
      vecs++; if (gnt1 !== 1'b0) begin fails++; $display("FAIL rst_gnt1 got=%0b exp=0", gnt1); end
      vecs++; if (gnt3 !== 1'b0) begin fails++; $display("FAIL rst_gnt3 got=%0b exp=0", gnt3); end
      vecs++; if (rv1 !== 1'b0) begin fails++; $display("FAIL rst_rv1 got=%0b exp=0", rv1); end
      vecs++; if (rd1 !== 32'h0) begin fails++; $display("FAIL rst_rd1 got=%h exp=0", rd1); end
      vecs++; if (re1 !== 1'b0) begin fails++; $display("FAIL rst_re1 got=%0b exp=0", re1); end
      vecs++; if (rv2 !== 1'b0 || rv3 !== 1'b0) begin fails++; $display("FAIL rst_rv23 got=%0b%0b exp=00", rv2, rv3); end
      rstn = 1'b1;
      idle(1);
   endtask

   task automatic test_write_read();
      idle(4);
      drv(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF); #1;
      vecs++; if (gnt1 !== 1'b1) begin fails++; $display("FAIL wr_gnt got=%0b exp=1", gnt1); end
      tick();
      drv(1'b1, 1'b0, 32'h10, 32'h0, 4'h0); #1;
      vecs++; if (gnt1 !== 1'b1) begin fails++; $display("FAIL rd_gnt got=%0b exp=1", gnt1); end
      vecs++; if (rv1 !== 1'b1) begin fails++; $display("FAIL wr_rsp_valid got=%0b exp=1", rv1); end
      vecs++; if (rd1 !== 32'h0) begin fails++; $display("FAIL wr_rsp_data got=%h exp=0", rd1); end
      vecs++; if (re1 !== 1'b0) begin fails++; $display("FAIL wr_rsp_err got=%0b exp=0", re1); end
      tick();
      drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
      vecs++; if (rv1 !== 1'b1) begin fails++; $display("FAIL rd_rsp_valid got=%0b exp=1", rv1); end
      vecs++; if (rd1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_rsp_data got=%h exp=deadbeef", rd1); end
      vecs++; if (re1 !== 1'b0) begin fails++; $display("FAIL rd_rsp_err got=%0b exp=0", re1); end
      tick();
      vecs++; if (rv1 !== 1'b0 || rd1 !== 32'h0) begin fails++; $display("FAIL rsp_single_cycle got=%0b/%h exp=0/0", rv1, rd1); end
   endtask

   task automatic test_byte_enable();
      idle(4);
      drv(1'b1, 1'b1, 32'h10, 32'h1122_3344, 4'h5); tick();
      drv(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0); tick();
      drv(1'b1, 1'b1, 32'h3FC, 32'h55AA_55AA, 4'hF); tick();
      drv(1'b1, 1'b0, 32'h13, 32'h0, 4'h0); #1;
      vecs++; if (rv1 !== 1'b1 || re1 !== 1'b0) begin fails++; $display("FAIL top_wr_rsp got=%0b/%0b exp=1/0", rv1, re1); end
      tick();
      drv(1'b1, 1'b0, 32'h3FC, 32'h0, 4'h0); #1;
      vecs++; if (rd1 !== 32'hDE22_BE44) begin fails++; $display("FAIL be_merge got=%h exp=de22be44", rd1); end
      tick();
      drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
      vecs++; if (rv1 !== 1'b1 || re1 !== 1'b0 || rd1 !== 32'h55AA_55AA) begin
         fails++; $display("FAIL last_word got=%0b/%0b/%h exp=1/0/55aa55aa", rv1, re1, rd1); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d;
      logic        exp_v;
      idle(4);
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF); tick();
      end
      idle(4);
      for (int k = 0; k < 8; k++) begin
         if (k < 4) drv(1'b1, 1'b0, 32'(4 * k), 32'h0, 4'h0);
         else       drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
         #1;
         vecs++; if (gnt3 !== (k < 4)) begin fails++; $display("FAIL b2b_gnt k=%0d got=%0b exp=%0b", k, gnt3, k < 4); end
         exp_v = (k >= 3 && k <= 6);
         exp_d = exp_v ? 32'hA000_0000 + 32'(k - 3) : 32'h0;
         vecs++; if (rv3 !== exp_v || rd3 !== exp_d || re3 !== 1'b0) begin
            fails++; $display("FAIL b2b_lat3 k=%0d got=%0b/%h exp=%0b/%h", k, rv3, rd3, exp_v, exp_d); end
         exp_v = (k >= 1 && k <= 4);
         exp_d = exp_v ? 32'hA000_0000 + 32'(k - 1) : 32'h0;
         vecs++; if (rv1 !== exp_v || rd1 !== exp_d) begin
            fails++; $display("FAIL b2b_lat1 k=%0d got=%0b/%h exp=%0b/%h", k, rv1, rd1, exp_v, exp_d); end
         tick();
      end
   endtask

   task automatic test_stall();
      idle(4);
      stall = 1'b1;
      drv(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         #1;
         vecs++; if (gnt1 !== 1'b0) begin fails++; $display("FAIL stall_gnt i=%0d got=%0b exp=0", i, gnt1); end
         vecs++; if (rv1 !== 1'b0 || rv2 !== 1'b0) begin fails++; $display("FAIL stall_rv i=%0d got=%0b%0b exp=00", i, rv1, rv2); end
         tick();
      end
      stall = 1'b0; #1;
      vecs++; if (gnt2 !== 1'b1) begin fails++; $display("FAIL release_gnt got=%0b exp=1", gnt2); end
      tick();
      drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
      vecs++; if (rv1 !== 1'b1 || rd1 !== 32'hA000_0001) begin fails++; $display("FAIL release_lat1 got=%0b/%h exp=1/a0000001", rv1, rd1); end
      vecs++; if (rv2 !== 1'b0) begin fails++; $display("FAIL release_lat2_early got=%0b exp=0", rv2); end
      tick();
      vecs++; if (rv2 !== 1'b1 || rd2 !== 32'hA000_0001) begin fails++; $display("FAIL release_lat2 got=%0b/%h exp=1/a0000001", rv2, rd2); end
      vecs++; if (rv1 !== 1'b0) begin fails++; $display("FAIL release_lat1_once got=%0b exp=0", rv1); end
      tick();
   endtask

   task automatic test_out_of_range();
      idle(4);
      drv(1'b1, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF); #1;
      vecs++; if (gnt1 !== 1'b1) begin fails++; $display("FAIL oor_gnt got=%0b exp=1", gnt1); end
      tick();
      drv(1'b1, 1'b0, 32'h0, 32'h0, 4'h0); #1;
      vecs++; if (rv1 !== 1'b1 || re1 !== 1'b1 || rd1 !== 32'h0) begin
         fails++; $display("FAIL oor_wr_rsp got=%0b/%0b/%h exp=1/1/0", rv1, re1, rd1); end
      tick();
      drv(1'b1, 1'b0, 32'h400, 32'h0, 4'h0); #1;
      vecs++; if (rv1 !== 1'b1 || re1 !== 1'b0 || rd1 !== 32'hA000_0000) begin
         fails++; $display("FAIL oor_word0_kept got=%0b/%0b/%h exp=1/0/a0000000", rv1, re1, rd1); end
      tick();
      drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
      vecs++; if (rv1 !== 1'b1 || re1 !== 1'b1 || rd1 !== 32'h0) begin
         fails++; $display("FAIL oor_rd_rsp got=%0b/%0b/%h exp=1/1/0", rv1, re1, rd1); end
      tick();
      vecs++; if (rv1 !== 1'b0 || re1 !== 1'b0) begin fails++; $display("FAIL oor_idle got=%0b/%0b exp=0/0", rv1, re1); end
   endtask

   task automatic test_reset_inflight();
      idle(4);
      drv(1'b1, 1'b0, 32'h10, 32'h0, 4'h0); #1;
      vecs++; if (gnt2 !== 1'b1) begin fails++; $display("FAIL inflight_gnt got=%0b exp=1", gnt2); end
      tick();
      rstn = 1'b0;
      drv(1'b1, 1'b1, 32'h10, 32'h0, 4'hF); #1;
      vecs++; if (gnt2 !== 1'b0) begin fails++; $display("FAIL rst_req_gnt got=%0b exp=0", gnt2); end
      tick();
      rstn = 1'b1;
      drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
      vecs++; if (rv2 !== 1'b0 || rd2 !== 32'h0 || re2 !== 1'b0) begin
         fails++; $display("FAIL inflight_drop2 got=%0b/%h/%0b exp=0/0/0", rv2, rd2, re2); end
      tick();
      vecs++; if (rv3 !== 1'b0) begin fails++; $display("FAIL inflight_drop3 got=%0b exp=0", rv3); end
      drv(1'b1, 1'b0, 32'h10, 32'h0, 4'h0); tick();
      drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
      vecs++; if (rv2 !== 1'b0) begin fails++; $display("FAIL retain_early got=%0b exp=0", rv2); end
      tick();
      vecs++; if (rv2 !== 1'b1 || rd2 !== 32'hDE22_BE44 || re2 !== 1'b0) begin
         fails++; $display("FAIL retain_data got=%0b/%h/%0b exp=1/de22be44/0", rv2, rd2, re2); end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; stall = 1'b0;
      drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      test_reset();
      test_write_read();
      test_byte_enable();
      test_back_to_back();
      test_stall();
      test_out_of_range();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
